cmp_seq_arbiter: RTL and testbench

- Controller that shares one combinational W-bit magnitude comparator between two requesters.
- Extends the comparator to NWORDS*W-bit operands by scanning word-serially, most-significant word first, and stopping at the first unequal word.
- Sits between operand-producing logic and the shared comparator.
- Arbitrates round-robin, sequences the compare, returns a registered gt/eq/lt result with a one-cycle done pulse.

---
 rtl/cmp_seq_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cmp_seq_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_seq_arbiter.sv
// cmp_seq_arbiter
// Shares one combinational W-bit magnitude comparator between two requesters
// and extends it to NWORDS*W-bit operands. Operands are scanned one word per
// cycle from the most significant word down, and the scan stops at the first
// unequal word. The requester is picked round-robin, and the result is
// returned with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req[1:0]              level requests, held until the matching done pulse
//   opa0/opb0, opa1/opb1  NWORDS*W-bit operands per requester, captured at grant
//   gnt[1:0]              one-hot grant, held from capture until done
//   done[1:0]             one-cycle pulse to the served requester
//   res_gt/res_eq/res_lt  registered compare result, held until the next done
//   err                   comparator flags were not one-hot during the scan
//   busy                  high while scanning or signalling done
//   cmp_a/cmp_b           current word pair driven to the shared comparator
//   cmp_gt/cmp_eq/cmp_lt  comparator response (combinational from cmp_a/cmp_b)

module cmp_seq_arbiter #(
   parameter int unsigned W      = 16,
   parameter int unsigned NWORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req,
   input  logic [NWORDS*W-1:0]   opa0,
   input  logic [NWORDS*W-1:0]   opb0,
   input  logic [NWORDS*W-1:0]   opa1,
   input  logic [NWORDS*W-1:0]   opb1,
   output logic [1:0]            gnt,
   output logic [1:0]            done,
   output logic                  res_gt,
   output logic                  res_eq,
   output logic                  res_lt,
   output logic                  err,
   output logic                  busy,
   output logic [W-1:0]          cmp_a,
   output logic [W-1:0]          cmp_b,
   input  logic                  cmp_gt,
   input  logic                  cmp_eq,
   input  logic                  cmp_lt
);

   // Index width stays at least one bit so NWORDS=1 still builds.
   localparam int unsigned IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [IW-1:0] IdxTop = IW'(NWORDS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StDone
   } state_t;

   state_t                r_state;
   logic [NWORDS*W-1:0]   r_opa;
   logic [NWORDS*W-1:0]   r_opb;
   logic [IW-1:0]         r_idx;
   logic [1:0]            r_gnt;
   logic [1:0]            r_done;
   logic                  r_res_gt;
   logic                  r_res_eq;
   logic                  r_res_lt;
   logic                  r_err;
   // Index of the requester served most recently; reset to 1 so requester 0
   // wins the first simultaneous request.
   logic                  r_last;

   logic                  w_pick1;
   logic                  w_flags_ok;
   logic [W-1:0]          w_word_a;
   logic [W-1:0]          w_word_b;

   // Requester 1 wins when it is alone, or when both ask and 0 went last.
   assign w_pick1 = req[1] & (~req[0] | ~r_last);

   // Exactly one of gt/eq/lt must be set for a trustworthy response.
   assign w_flags_ok = ({cmp_gt, cmp_eq, cmp_lt} == 3'b100) ||
                       ({cmp_gt, cmp_eq, cmp_lt} == 3'b010) ||
                       ({cmp_gt, cmp_eq, cmp_lt} == 3'b001);

   always_comb begin
      w_word_a = '0;
      w_word_b = '0;
      for (int i = 0; i < int'(NWORDS); i++) begin
         if (r_idx == IW'(i)) begin
            w_word_a = r_opa[i*W +: W];
            w_word_b = r_opb[i*W +: W];
         end
      end
   end

   // The comparator bus is quiet outside the scan.
   assign cmp_a = (r_state == StScan) ? w_word_a : '0;
   assign cmp_b = (r_state == StScan) ? w_word_b : '0;

   assign gnt    = r_gnt;
   assign done   = r_done;
   assign res_gt = r_res_gt;
   assign res_eq = r_res_eq;
   assign res_lt = r_res_lt;
   assign err    = r_err;
   assign busy   = (r_state != StIdle);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= StIdle;
         r_opa    <= '0;
         r_opb    <= '0;
         r_idx    <= '0;
         r_gnt    <= 2'b00;
         r_done   <= 2'b00;
         r_res_gt <= 1'b0;
         r_res_eq <= 1'b0;
         r_res_lt <= 1'b0;
         r_err    <= 1'b0;
         r_last   <= 1'b1;
      end else begin
         case (r_state)
            StIdle: begin
               if (req != 2'b00) begin
                  if (w_pick1) begin
                     r_opa <= opa1;
                     r_opb <= opb1;
                     r_gnt <= 2'b10;
                  end else begin
                     r_opa <= opa0;
                     r_opb <= opb0;
                     r_gnt <= 2'b01;
                  end
                  r_idx   <= IdxTop;
                  r_state <= StScan;
               end
            end

            StScan: begin
               if (!w_flags_ok) begin
                  r_err    <= 1'b1;
                  r_res_gt <= 1'b0;
                  r_res_eq <= 1'b0;
                  r_res_lt <= 1'b0;
                  r_done   <= r_gnt;
                  r_state  <= StDone;
               end else if (!cmp_eq || (r_idx == '0)) begin
                  // First unequal word decides; all-equal ends at word 0.
                  r_err    <= 1'b0;
                  r_res_gt <= cmp_gt;
                  r_res_eq <= cmp_eq;
                  r_res_lt <= cmp_lt;
                  r_done   <= r_gnt;
                  r_state  <= StDone;
               end else begin
                  r_idx <= r_idx - IW'(1);
               end
            end

            StDone: begin
               r_done  <= 2'b00;
               r_last  <= r_gnt[1];
               r_gnt   <= 2'b00;
               r_state <= StIdle;
            end

            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_seq_arbiter.sv
// Directed testbench for cmp_seq_arbiter with a behavioural comparator that
// can be told to return an illegal flag set on one specific word value.

module tb_cmp_seq_arbiter;

   localparam int unsigned W      = 16;
   localparam int unsigned NWORDS = 4;

   logic                clk;
   logic                rst_n;
   logic [1:0]          req;
   logic [NWORDS*W-1:0] opa0, opb0, opa1, opb1;
   logic [1:0]          gnt, done;
   logic                res_gt, res_eq, res_lt, err, busy;
   logic [W-1:0]        cmp_a, cmp_b;
   logic                cmp_gt, cmp_eq, cmp_lt;
   logic                fault_en;

   int n_checks = 0;
   int n_pass   = 0;

   cmp_seq_arbiter #(
      .W      (W),
      .NWORDS (NWORDS)
   ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .opa0   (opa0),
      .opb0   (opb0),
      .opa1   (opa1),
      .opb1   (opb1),
      .gnt    (gnt),
      .done   (done),
      .res_gt (res_gt),
      .res_eq (res_eq),
      .res_lt (res_lt),
      .err    (err),
      .busy   (busy),
      .cmp_a  (cmp_a),
      .cmp_b  (cmp_b),
      .cmp_gt (cmp_gt),
      .cmp_eq (cmp_eq),
      .cmp_lt (cmp_lt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared comparator; with fault_en it answers gt=eq=1 for word 16'h0002.
   always_comb begin
      cmp_gt = (cmp_a > cmp_b);
      cmp_eq = (cmp_a == cmp_b);
      cmp_lt = (cmp_a < cmp_b);
      if (fault_en && (cmp_a == 16'h0002)) begin
         cmp_gt = 1'b1;
         cmp_eq = 1'b1;
         cmp_lt = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] t1_words [4];
   int          cyc;
   int          last_cyc;
   int          budget;
   logic        two_hot;

   initial begin
      t1_words = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
      fault_en = 1'b0;
      rst_n    = 1'b0;
      req      = 2'b00;
      opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0;
      tick();
      tick();
      check("rst_gnt",  {62'd0, gnt},  64'd0);
      check("rst_done", {62'd0, done}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_cmpa", {48'd0, cmp_a}, 64'd0);
      check("rst_res",  {61'd0, res_gt, res_eq, res_lt}, 64'd0);
      rst_n = 1'b1;

      // All-equal 64-bit compare, full 4-word scan.
      opa0 = 64'h1234_5678_9ABC_DEF0;
      opb0 = 64'h1234_5678_9ABC_DEF0;
      req  = 2'b01;
      tick();
      check("t1_gnt",  {62'd0, gnt},  64'h1);
      check("t1_busy", {63'd0, busy}, 64'h1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         check($sformatf("t1_cmpa%0d", i), {48'd0, cmp_a}, {48'd0, t1_words[i]});
         check($sformatf("t1_cmpb%0d", i), {48'd0, cmp_b}, {48'd0, t1_words[i]});
      end
      tick();
      check("t1_done", {62'd0, done}, 64'h1);
      check("t1_res",  {61'd0, res_gt, res_eq, res_lt}, 64'h2);
      req = 2'b00;
      tick();
      check("t1_done_off", {62'd0, done}, 64'h0);
      check("t1_gnt_off",  {62'd0, gnt},  64'h0);
      check("t1_res_hold", {61'd0, res_gt, res_eq, res_lt}, 64'h2);

      // Early stop on the top word.
      opa1 = 64'h0002_0000_0000_0000;
      opb1 = 64'h0001_FFFF_FFFF_FFFF;
      req  = 2'b10;
      tick();
      check("t2_gnt",  {62'd0, gnt},   64'h2);
      check("t2_cmpa", {48'd0, cmp_a}, 64'h0002);
      tick();
      check("t2_done", {62'd0, done}, 64'h2);
      check("t2_res",  {61'd0, res_gt, res_eq, res_lt}, 64'h4);
      req = 2'b00;
      tick();

      // Both requesting from reset: served 0,1,0,1 with dones 6 cycles apart.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      opa0 = 64'h1111_2222_3333_4444; opb0 = opa0;
      opa1 = 64'h5555_6666_7777_8888; opb1 = opa1;
      req  = 2'b11;
      cyc = 0; last_cyc = 0; two_hot = 1'b0;
      for (int k = 0; k < 4; k++) begin
         budget = 0;
         do begin
            tick();
            cyc++;
            budget++;
            if (gnt == 2'b11) two_hot = 1'b1;
         end while ((done == 2'b00) && (budget < 20));
         if (budget >= 20) check($sformatf("t3_timeout%0d", k), 64'd1, 64'd0);
         check($sformatf("t3_done%0d", k), {62'd0, done}, (k % 2 == 0) ? 64'h1 : 64'h2);
         if (k == 0) check("t3_first_cyc", 64'(cyc), 64'd5);
         else check($sformatf("t3_gap%0d", k), 64'(cyc - last_cyc), 64'd6);
         last_cyc = cyc;
      end
      check("t3_gnt_onehot", {63'd0, two_hot}, 64'd0);
      req = 2'b00;
      tick();

      // Illegal comparator flags on word 2.
      opa0 = 64'h0003_0002_0001_0000;
      opb0 = 64'h0003_0002_0001_0000;
      fault_en = 1'b1;
      req = 2'b01;
      tick();
      tick();
      check("t4_cmpa_w2", {48'd0, cmp_a}, 64'h0002);
      tick();
      check("t4_done", {62'd0, done}, 64'h1);
      check("t4_err",  {63'd0, err},  64'h1);
      check("t4_res",  {61'd0, res_gt, res_eq, res_lt}, 64'h0);
      req = 2'b00;
      fault_en = 1'b0;
      tick();

      // Reset during the second scan cycle of requester 1's compare.
      opa1 = 64'hAAAA_BBBB_CCCC_DDDD; opb1 = opa1;
      opa0 = 64'h0000_0000_0000_0001;
      opb0 = 64'h0000_0000_0000_0002;
      req  = 2'b11;
      tick();
      check("t5_gnt_pre", {62'd0, gnt}, 64'h2);
      tick();
      check("t5_cmpa_pre", {48'd0, cmp_a}, 64'hBBBB);
      rst_n = 1'b0;
      #1;
      check("t5_rst_gnt",  {62'd0, gnt},   64'h0);
      check("t5_rst_busy", {63'd0, busy},  64'h0);
      check("t5_rst_cmpa", {48'd0, cmp_a}, 64'h0);
      check("t5_rst_err",  {63'd0, err},   64'h0);
      tick();
      check("t5_rst_done", {62'd0, done}, 64'h0);
      rst_n = 1'b1;
      tick();
      check("t5_gnt_post", {62'd0, gnt}, 64'h1);
      req = 2'b01;
      tick();
      tick();
      tick();
      check("t6_cmpa_w0", {48'd0, cmp_a}, 64'h0001);
      check("t6_cmpb_w0", {48'd0, cmp_b}, 64'h0002);
      tick();
      check("t6_done", {62'd0, done}, 64'h1);
      check("t6_res",  {61'd0, res_gt, res_eq, res_lt}, 64'h1);
      req = 2'b11;
      tick();
      check("t6_idle_gnt", {62'd0, gnt}, 64'h0);
      tick();
      check("t6_rr_gnt", {62'd0, gnt}, 64'h2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
